// File: rtl/es9821_pkg.sv
// es9821_pkg: shared types and the fixed power-up register table for the
// ES9821Q configuration sequencer.
//   cfg_state_e      : sequencer state encoding
//   CFG_LEN          : number of table entries
//   CFG_REG/CFG_DAT  : {register address, data} pairs, sent in index order
package es9821_pkg;

  localparam int CFG_LEN = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_REQ,
    S_WAIT_DONE,
    S_FAIL,
    S_NEXT,
    S_GAP,
    S_DONE,
    S_ERROR
  } cfg_state_e;

  localparam logic [7:0] CFG_REG [CFG_LEN] = '{8'h1D, 8'h1A, 8'h03, 8'h04,
                                               8'h02, 8'h01, 8'h02, 8'h00};
  localparam logic [7:0] CFG_DAT [CFG_LEN] = '{8'h00, 8'h11, 8'h00, 8'h82,
                                               8'h01, 8'h00, 8'h03, 8'h10};

endpackage

// File: rtl/es9821_cfg_sequencer_if.sv
// es9821_cfg_sequencer_if: register-write handshake between the sequencer
// (master) and the I2C write engine (slave).
//   i2c_start     : level write request, held until the engine goes busy
//   i2c_addr      : 7-bit device address
//   i2c_reg       : register address of the current write
//   i2c_data      : data byte of the current write
//   i2c_busy      : engine busy
//   i2c_ack_error : NACK flag, valid on the busy falling edge
interface es9821_cfg_sequencer_if;
  logic       i2c_start;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_data;
  logic       i2c_busy;
  logic       i2c_ack_error;

  modport master (output i2c_start, i2c_addr, i2c_reg, i2c_data,
                  input  i2c_busy, i2c_ack_error);
  modport slave  (input  i2c_start, i2c_addr, i2c_reg, i2c_data,
                  output i2c_busy, i2c_ack_error);
endinterface

// File: rtl/es9821_cfg_sequencer.sv
// es9821_cfg_sequencer: power-up configuration sequencer for the ES9821Q ADC.
// Waits PWRUP_CYCLES after launch, then writes each table entry through the
// I2C write engine, retrying failed writes, and reports done/error.
// Ports:
//   clk, reset     : single clock, synchronous active-high reset
//   cfg_start      : launch pulse (honoured only in IDLE/DONE/ERROR)
//   i2c            : master side of the engine handshake
//   cfg_busy       : sequence in progress
//   cfg_done       : all entries written (sticky until launch/reset)
//   cfg_error      : sequence aborted (sticky until launch/reset)
//   err_index      : table index of the failing entry
// Build option: define ES9821_CFG_RETRY_EN to enable per-entry retries;
// without it a failed write aborts immediately and no retry counter exists.
module es9821_cfg_sequencer
  import es9821_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h48,
  parameter int         PWRUP_CYCLES   = 500000,
  parameter int         GAP_CYCLES     = 5000,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  es9821_cfg_sequencer_if.master        i2c,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_error,
  output logic [3:0]                    err_index
);

  // One shared down-counter covers power-up wait, gap and timeout.
  localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES)
                         ? ((PWRUP_CYCLES > TIMEOUT_CYCLES) ? PWRUP_CYCLES : TIMEOUT_CYCLES)
                         : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  // Waits load N-1 so the state lasts exactly N cycles; the timeout loads N
  // so i2c_start is held high for N cycles before giving up.
  localparam logic [CNT_W-1:0] C_PWR = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TMO = CNT_W'(TIMEOUT_CYCLES);

  cfg_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_start;
  logic [7:0]       r_reg;
  logic [7:0]       r_dat;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [3:0]       r_err_idx;
  logic             w_retry_ok;

`ifdef ES9821_CFG_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] r_retry;
  assign w_retry_ok = (r_retry < RETRY_W'(MAX_RETRY));
`else
  // Retries compiled out: a failed write always aborts.
  assign w_retry_ok = (MAX_RETRY < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_start   <= 1'b0;
      r_reg     <= '0;
      r_dat     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
`ifdef ES9821_CFG_RETRY_EN
      r_retry   <= '0;
`endif
    end else begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (cfg_start) begin
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
            r_idx     <= '0;
`ifdef ES9821_CFG_RETRY_EN
            r_retry   <= '0;
`endif
            r_busy    <= 1'b1;
            r_cnt     <= C_PWR;
            r_state   <= S_PWR_WAIT;
          end
        end
        // reg/data latch on REQ entry and stay put until WAIT_DONE exits.
        S_PWR_WAIT, S_GAP: begin
          if (r_cnt == '0) begin
            r_reg   <= CFG_REG[r_idx];
            r_dat   <= CFG_DAT[r_idx];
            r_cnt   <= C_TMO;
            r_state <= S_REQ;
          end
        end
        // Busy already high (even left over) counts as the request taken.
        S_REQ: begin
          if (i2c.i2c_busy) begin
            r_start <= 1'b0;
            r_cnt   <= C_TMO;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == '0) begin
            r_start <= 1'b0;
            r_state <= S_FAIL;
          end else begin
            r_start <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!i2c.i2c_busy)
            r_state <= i2c.i2c_ack_error ? S_FAIL : S_NEXT;
          else if (r_cnt == '0)
            r_state <= S_FAIL;
        end
        S_FAIL: begin
          if (w_retry_ok) begin
`ifdef ES9821_CFG_RETRY_EN
            r_retry <= r_retry + 1'b1;
`endif
            r_cnt   <= C_GAP;
            r_state <= S_GAP;
          end else begin
            r_error   <= 1'b1;
            r_err_idx <= {1'b0, r_idx};
            r_busy    <= 1'b0;
            r_state   <= S_ERROR;
          end
        end
        S_NEXT: begin
`ifdef ES9821_CFG_RETRY_EN
          r_retry <= '0;
`endif
          if (r_idx == 3'(CFG_LEN - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= C_GAP;
            r_state <= S_GAP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i2c.i2c_start = r_start;
  assign i2c.i2c_addr  = DEV_ADDR;
  assign i2c.i2c_reg   = r_reg;
  assign i2c.i2c_data  = r_dat;
  assign cfg_busy      = r_busy;
  assign cfg_done      = r_done;
  assign cfg_error     = r_error;
  assign err_index     = r_err_idx;

endmodule

// File: tb/tb_es9821_cfg_sequencer.sv
// tb_es9821_cfg_sequencer: directed and randomized runs of the configuration
// sequencer against a cycle-level I2C engine model and a request-list
// reference model. Honours ES9821_CFG_RETRY_EN for the expected retry count.
module tb_es9821_cfg_sequencer;

  localparam int PWR = 10;
  localparam int GAP = 4;
  localparam int TMO = 50;
  localparam int MR  = 2;
`ifdef ES9821_CFG_RETRY_EN
  localparam int EFF = MR;
`else
  localparam int EFF = 0;
`endif

  localparam logic [7:0] T_REG [8] = '{8'h1D, 8'h1A, 8'h03, 8'h04, 8'h02, 8'h01, 8'h02, 8'h00};
  localparam logic [7:0] T_DAT [8] = '{8'h00, 8'h11, 8'h00, 8'h82, 8'h01, 8'h00, 8'h03, 8'h10};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_busy, cfg_done, cfg_error;
  logic [3:0] err_index;

  es9821_cfg_sequencer_if bus();

  always #5 clk = ~clk;

  es9821_cfg_sequencer #(
    .DEV_ADDR(7'h48), .PWRUP_CYCLES(PWR), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .i2c(bus.master),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .err_index(err_index)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [22:0] obs_q[$];
  logic [22:0] exp_q[$];
  int fail_n [8];
  bit fail_nr[8];
  int att [8];
  int last_fall_cyc = 0;
  int launch_cyc = 0;
  bit ack_fall = 0;
  bit first_pend = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int find_idx(input logic [7:0] r, input logic [7:0] d);
    for (int i = 0; i < 8; i++) if (T_REG[i] == r && T_DAT[i] == d) return i;
    return -1;
  endfunction

  // Reference: entry i fails its first fail_n[i] attempts; more failures
  // than allowed retries aborts the sequence at that entry.
  task automatic model(output bit e_err, output int e_idx);
    exp_q.delete();
    e_err = 0;
    e_idx = 0;
    for (int i = 0; i < 8; i++) begin
      int tries;
      tries = (fail_n[i] > EFF) ? EFF + 1 : fail_n[i] + 1;
      repeat (tries) exp_q.push_back({7'h48, T_REG[i], T_DAT[i]});
      if (fail_n[i] > EFF) begin
        e_err = 1;
        e_idx = i;
        break;
      end
    end
  endtask

  // Monitor plus engine model: busy rises 3 cycles after start is seen,
  // stays high 20 cycles; planned failures either NACK or never respond.
  initial begin
    int ph, cnt, len, idx;
    bit nack, nr;
    logic ps, pd;
    ph = 0; cnt = 0; len = 0; nack = 0; ps = 0; pd = 0;
    bus.i2c_busy = 1'b0;
    bus.i2c_ack_error = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        ph = 0; bus.i2c_busy = 1'b0; bus.i2c_ack_error = 1'b0;
        ps = 0; pd = 0; len = 0;
        continue;
      end
      if (bus.i2c_start && !ps) begin
        obs_q.push_back({bus.i2c_addr, bus.i2c_reg, bus.i2c_data});
        idx = find_idx(bus.i2c_reg, bus.i2c_data);
        if (idx >= 0) att[idx]++;
        if (first_pend) begin
          chk("pwrup_lat", 32'(cyc - launch_cyc), 32'(PWR + 2));
          first_pend = 0;
        end else if (ack_fall) begin
          // busy driven low just after edge p, sampled by the DUT at p+1
          chk("gap_lat", 32'(cyc - last_fall_cyc), 32'(GAP + 3));
        end
        ack_fall = 0;
        len = 0;
      end
      if (bus.i2c_start) len++;
      if (!bus.i2c_start && ps && !bus.i2c_busy) chk("tmo_len", 32'(len), 32'(TMO));
      if (cfg_done && !pd) chk("done_lat", 32'(cyc - last_fall_cyc), 32'd2);
      ps = bus.i2c_start;
      pd = cfg_done;
      case (ph)
        0: if (bus.i2c_start) begin
          idx = find_idx(bus.i2c_reg, bus.i2c_data);
          nr = (idx >= 0) && (att[idx] <= fail_n[idx]) && fail_nr[idx];
          if (!nr) begin
            nack = (idx >= 0) && (att[idx] <= fail_n[idx]);
            ph = 1; cnt = 2;
          end
        end
        1: if (cnt == 0) begin
          bus.i2c_busy = 1'b1; bus.i2c_ack_error = 1'b0; ph = 2; cnt = 19;
        end else cnt--;
        default: if (cnt == 0) begin
          chk("reg_hold", 32'({bus.i2c_addr, bus.i2c_reg, bus.i2c_data}), 32'(obs_q[$]));
          bus.i2c_busy = 1'b0; bus.i2c_ack_error = nack;
          last_fall_cyc = cyc; ack_fall = !nack; ph = 0;
        end else cnt--;
      endcase
    end
  end

  task automatic set_plan(input int fi, input int fn, input bit nr);
    for (int i = 0; i < 8; i++) begin fail_n[i] = 0; fail_nr[i] = 0; end
    if (fi >= 0) begin fail_n[fi] = fn; fail_nr[fi] = nr; end
  endtask

  task automatic launch();
    for (int i = 0; i < 8; i++) att[i] = 0;
    obs_q.delete();
    ack_fall = 0;
    first_pend = 1;
    cfg_start = 1'b1;
    launch_cyc = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic run_check(input string name);
    int t, n, e_idx;
    bit poked, e_err;
    launch();
    chk({name, ":busy_on"}, 32'({cfg_busy, cfg_done, cfg_error}), 32'b100);
    t = 0; poked = 0;
    while (!(cfg_done || cfg_error) && t < 6000) begin
      @(negedge clk);
      t++;
      // launches mid-sequence must be ignored
      if (t == 3 || (!poked && obs_q.size() == 2 && cfg_busy)) begin
        if (t != 3) poked = 1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
      end
    end
    chk({name, ":in_budget"}, 32'(t < 6000), 32'd1);
    repeat (40) @(negedge clk);
    model(e_err, e_idx);
    chk({name, ":n_req"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, ":req"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({name, ":done"}, 32'(cfg_done), 32'(!e_err));
    chk({name, ":error"}, 32'(cfg_error), 32'(e_err));
    chk({name, ":busy_off"}, 32'(cfg_busy), 32'd0);
    chk({name, ":err_index"}, 32'(err_index), 32'(e_err ? e_idx : 0));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ":start"}, 32'(bus.i2c_start), 32'd0);
    chk({name, ":reg_dat"}, 32'({bus.i2c_reg, bus.i2c_data}), 32'd0);
    chk({name, ":status"}, 32'({cfg_busy, cfg_done, cfg_error, err_index}), 32'd0);
  endtask

  initial begin
    int t;
    set_plan(-1, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    set_plan(-1, 0, 0); run_check("nominal");
    set_plan(3, 1, 0);  run_check("retry_e3");
    set_plan(5, 3, 0);  run_check("exhaust_e5");
    set_plan(0, 3, 1);  run_check("timeout_e0");
    set_plan(1, 1, 0);  run_check("nack_e1");

    // reset while entry 2 is in flight
    set_plan(-1, 0, 0);
    launch();
    t = 0;
    while (!(obs_q.size() == 3 && bus.i2c_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("midreset:reach_e2", 32'(t < 3000), 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_check("after_reset");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        fail_n[i]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, EFF + 1)) : 0;
        fail_nr[i] = 1'($urandom_range(0, 1));
      end
      run_check($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/es9821_cfg_sequencer.md
# es9821_cfg_sequencer

Power-up configuration sequencer for the ES9821Q ADC. It waits a settle time after reset, then walks a fixed table of {register address, data} pairs. Each pair is handed as one register-write request to the downstream I2C write engine, using that engine's start/busy/ack_error handshake. Failed writes are retried, and the block reports done or error status to the system control logic.

## Interface
Parameters:
- `DEV_ADDR`, 7'h48: 7-bit I2C address of the ADC, driven on `i2c_addr`.
- `PWRUP_CYCLES`, 500000: clk cycles between launch and the first write (10 ms at 50 MHz).
- `GAP_CYCLES`, 5000: idle clk cycles between completion of one write and the next request.
- `TIMEOUT_CYCLES`, 1000000: maximum clk cycles spent waiting on any single busy edge.
- `MAX_RETRY`, 3: extra attempts per entry after a failed write.

Ports:
- `clk`, in, 1: 50 MHz system clock. The only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cfg_start`, in, 1: launch pulse. Sampled only in IDLE, DONE and ERROR.
- `i2c_start`, out, 1: level write request to the I2C engine.
- `i2c_addr`, out, 7: device address. Constant `DEV_ADDR`.
- `i2c_reg`, out, 8: register address of the current entry.
- `i2c_data`, out, 8: data byte of the current entry.
- `i2c_busy`, in, 1: engine busy.
- `i2c_ack_error`, in, 1: engine NACK flag. Valid on the busy falling edge.
- `cfg_busy`, out, 1: sequence in progress.
- `cfg_done`, out, 1: all entries written. Sticky until the next launch or reset.
- `cfg_error`, out, 1: aborted. Sticky until the next launch or reset.
- `err_index`, out, 4: table index of the failing entry.

## Operation
- Reset values: `i2c_start`=0, `i2c_reg`=8'h00, `i2c_data`=8'h00, `cfg_busy`=0, `cfg_done`=0, `cfg_error`=0, `err_index`=0. All counters are 0 and the state is IDLE.
- The table has 8 entries, sent in index order:
  - 0: 1D/00
  - 1: 1A/11
  - 2: 03/00
  - 3: 04/82
  - 4: 02/01
  - 5: 01/00
  - 6: 02/03
  - 7: 00/10
- States and transitions:
  - IDLE / DONE / ERROR: on `cfg_start`, clear `cfg_done`, `cfg_error`, `err_index`, the index and the retry count; set `cfg_busy`; go to PWR_WAIT.
  - PWR_WAIT: count `PWRUP_CYCLES`, then go to REQ.
  - REQ: load `i2c_reg`/`i2c_data` from the table at the current index and hold `i2c_start`=1. When `i2c_busy`=1, drop `i2c_start` and go to WAIT_DONE. On timeout, go to FAIL.
  - WAIT_DONE: wait for `i2c_busy`=0. In that same cycle, if `i2c_ack_error`=1 go to FAIL, else go to NEXT. On timeout, go to FAIL.
  - FAIL: if retry count < `MAX_RETRY`, increment it and go to GAP with the index unchanged. Otherwise set `cfg_error`, set `err_index` to the index, clear `cfg_busy`, and go to ERROR.
  - NEXT: clear the retry count. If the index is 7, set `cfg_done`, clear `cfg_busy`, and go to DONE. Otherwise increment the index and go to GAP.
  - GAP: count `GAP_CYCLES`, then go to REQ.
- `i2c_start` is a level, not a pulse, because the I2C engine advances on a 100 kHz clock enable and would miss a 1-cycle pulse.
- `i2c_reg`/`i2c_data` stay stable from REQ entry until WAIT_DONE exit.
- `i2c_busy` already high on REQ entry, for example left over from a prior transaction, is accepted as the request being taken.
- `cfg_start` during PWR_WAIT through GAP is ignored.
- `reset` mid-transfer returns the block to IDLE in one cycle with `i2c_start`=0. The I2C engine must be reset by the same signal.
- Arithmetic:
  - One shared down-counter, sized by $clog2 of the maximum of the three cycle parameters, serves the wait, gap and timeout counts.
  - Index is 3 bits. `err_index` is the index zero-extended to 4 bits.
  - The retry counter is $clog2(`MAX_RETRY`+1) bits.

## Timing
- From `cfg_start` to `i2c_start` rising: `PWRUP_CYCLES`+1 cycles.
- From `i2c_busy` falling with ACK to the next `i2c_start` rising: `GAP_CYCLES`+2 cycles.
- `cfg_done` rises 1 cycle after the final `i2c_busy` falling edge.
- A timeout fires when the waited-for edge is absent for `TIMEOUT_CYCLES` consecutive cycles.
- The counter reloads on every state entry.
- All outputs are registered.

## Configuration
- `ES9821_CFG_RETRY_EN`:
  - Defined: retry behaviour as specified under Operation.
  - Undefined: FAIL always goes directly to ERROR (equivalent to `MAX_RETRY`=0), and the retry counter is not synthesized.

## Structure
- Package `es9821_pkg`:
  - Holds the state enum typedef, the 8-entry table as constant arrays `CFG_REG[8]`/`CFG_DAT[8]`, and `CFG_LEN`=8.
- No sub-module; the table is a constant function/array read combinationally by index.

## Test plan
Benches use `PWRUP_CYCLES`=10, `GAP_CYCLES`=4, `TIMEOUT_CYCLES`=50 and `MAX_RETRY`=2, with a behavioural engine model that raises busy 3 cycles after `i2c_start` and holds it for 20 cycles.
- Nominal run: pulse `cfg_start`, model always ACKs. Expect 8 requests in table order (1D/00 … 00/10), each with `i2c_addr`=7'h48, then `cfg_done`=1, `cfg_busy`=0, `cfg_error`=0.
- Single retry: NACK the first attempt of entry 3. Expect entry 3 (04/82) requested twice, then the sequence completes with `cfg_done`=1.
- Retry exhaustion: NACK entry 5 every time. Expect 3 attempts of 01/00, then `cfg_error`=1, `err_index`=5, and no further requests.
- Timeout: the model never raises busy on entry 0. Expect `i2c_start` held for 50 cycles, 3 attempts in total, then `cfg_error`=1, `err_index`=0.
- Reset mid-operation: assert `reset` during WAIT_DONE of entry 2. Next cycle expect all outputs at reset values; a following `cfg_start` restarts from entry 0.
- Retry disabled: build without `ES9821_CFG_RETRY_EN`, NACK entry 1 once. Expect immediate `cfg_error`=1, `err_index`=1.
